unified_mem_model: RTL and testbench

- Behavioural main-memory model used as the processor's backing store; implements the DUT named `mem` in the system bench.
- Accepts one load or store per cycle on the proc2mem bus.
- Hands back a transaction tag immediately and returns load data, marked with that tag, a fixed number of cycles later.
- Contents live in a 64-bit-line array named unified_memory. The bench preloads it hierarchically (readmemh) and dumps it at halt, so the array name and line indexing are fixed.

---
 rtl/unified_mem_if.sv | 21 ++
 rtl/unified_mem_model.sv | 95 +++++++++
 tb/tb_unified_mem_model.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_if.sv
// Processor-to-memory bus: one load/store request per cycle, tagged responses.
interface unified_mem_if #(
   parameter int XLEN = 32
);
   logic [1:0]      proc2mem_command;
   logic [XLEN-1:0] proc2mem_addr;
   logic [63:0]     proc2mem_data;
   logic [1:0]      proc2mem_size;
   logic [3:0]      mem2proc_response;
   logic [63:0]     mem2proc_data;
   logic [3:0]      mem2proc_tag;

   modport master (
      output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
      input  mem2proc_response, mem2proc_data, mem2proc_tag
   );
   modport slave (
      input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
      output mem2proc_response, mem2proc_data, mem2proc_tag
   );
endinterface

// File: rtl/unified_mem_model.sv
// Fixed-latency tagged main-memory model over a 64-bit-line array.
// Load data is read from the array in the cycle it is returned.
module unified_mem_model #(
   parameter int XLEN            = 32,
   parameter int MEM_64BIT_LINES = 8192,
   parameter int MEM_LATENCY     = 10,
   parameter int NUM_TAGS        = 15
) (
   input  logic         clock,
   input  logic         reset,
   unified_mem_if.slave bus
);
   localparam int TW = 4;
   localparam int IW = $clog2(MEM_64BIT_LINES);
   localparam int LW = XLEN - 3;
   localparam logic [LW-1:0] LINES = LW'(MEM_64BIT_LINES);

   typedef enum logic [1:0] {CMD_NONE = 2'd0, CMD_LOAD = 2'd1, CMD_STORE = 2'd2} cmd_e;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [IW-1:0] idx;
   } pend_t;

   logic [63:0]            unified_memory [MEM_64BIT_LINES];
   logic [NUM_TAGS:1]      busy;
   logic [MEM_LATENCY-1:0] vld_pipe;
   pend_t                  pend_pipe [MEM_LATENCY];
   logic [TW-1:0]          response;

   logic [LW-1:0] line;
   logic [IW-1:0] idx;
   logic [2:0]    off, shift;
   logic [7:0]    be;
   logic [63:0]   wdata;
   logic [TW-1:0] free_tag;
   logic          in_range, acc_load, acc_store;

   assign line     = bus.proc2mem_addr[XLEN-1:3];
   assign idx      = line[IW-1:0];
   assign off      = bus.proc2mem_addr[2:0];
   assign in_range = line < LINES;

   // Lowest-numbered tag not held by an outstanding load
   always_comb begin
      free_tag = '0;
      for (int t = NUM_TAGS; t >= 1; t--)
         if (!busy[t]) free_tag = TW'(t);
   end

   assign acc_load  = (bus.proc2mem_command == CMD_LOAD) && in_range && (free_tag != '0);
   assign acc_store = (bus.proc2mem_command == CMD_STORE) && in_range;

   always_comb begin
      shift = '0;
      be    = 8'hFF;
      case (bus.proc2mem_size)
         2'd0: begin shift = off;                be = 8'h01 << shift; end
         2'd1: begin shift = {off[2:1], 1'b0};   be = 8'h03 << shift; end
         2'd2: begin shift = {off[2], 2'b00};    be = 8'h0F << shift; end
         default: begin shift = '0;              be = 8'hFF;          end
      endcase
      wdata = bus.proc2mem_data << {shift, 3'b000};
   end

   // A store with no free tag still writes; its response is then 0
   always_ff @(posedge clock) begin
      if (reset) begin
         response <= '0;
         busy     <= '0;
         vld_pipe <= '0;
      end else begin
         response     <= (acc_load || acc_store) ? free_tag : '0;
         vld_pipe[0]  <= acc_load;
         pend_pipe[0] <= '{tag: free_tag, idx: idx};
         for (int k = 1; k < MEM_LATENCY; k++) begin
            vld_pipe[k]  <= vld_pipe[k-1];
            pend_pipe[k] <= pend_pipe[k-1];
         end
         if (vld_pipe[MEM_LATENCY-1]) busy[pend_pipe[MEM_LATENCY-1].tag] <= 1'b0;
         if (acc_load) busy[free_tag] <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && acc_store)
         for (int b = 0; b < 8; b++)
            if (be[b]) unified_memory[idx][b*8 +: 8] <= wdata[b*8 +: 8];
   end

   assign bus.mem2proc_response = response;
   assign bus.mem2proc_tag  = vld_pipe[MEM_LATENCY-1] ? pend_pipe[MEM_LATENCY-1].tag : '0;
   assign bus.mem2proc_data = vld_pipe[MEM_LATENCY-1] ?
                              unified_memory[pend_pipe[MEM_LATENCY-1].idx] : 64'd0;
endmodule

// File: tb/tb_unified_mem_model.sv
// Directed and random bus traffic checked against a tag/queue reference model.
module tb_unified_mem_model;
   localparam int LAT   = 15;
   localparam int LINES = 8192;
   localparam logic [1:0] LD = 2'd1, ST = 2'd2;

   logic clock = 1'b0;
   logic reset;

   unified_mem_if #(.XLEN(32)) bus ();

   unified_mem_model #(
      .XLEN(32), .MEM_64BIT_LINES(LINES), .MEM_LATENCY(LAT), .NUM_TAGS(15)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      int     tag;
      int     idx;
      longint ret;
   } pend_t;

   pend_t       pq[$];
   logic [63:0] mm [16];
   longint      busy_until [16];
   longint      ecnt = 0;
   logic [3:0]  exp_resp, exp_tag, o_resp, o_tag;
   logic [63:0] exp_data, o_data;
   int          n_chk = 0, n_pass = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, got, want);
   endtask

   // Reference: a tag is held from its accept edge e until it may be reallocated at e+LAT+1;
   // the load's line is shown in the cycle after edge e+LAT-1.
   task automatic model(input logic rst, input logic [1:0] c, input logic [31:0] a,
                        input logic [63:0] d, input logic [1:0] s);
      int idx, lt, n, base, offs;
      if (rst) begin
         pq.delete();
         for (int t = 0; t < 16; t++) busy_until[t] = -1;
         exp_resp = 0; exp_tag = 0; exp_data = 0;
         ecnt++;
         return;
      end
      idx  = int'(a[31:3]);
      offs = int'(a[2:0]);
      lt   = 0;
      for (int t = 1; t <= 15; t++)
         if (lt == 0 && ecnt > busy_until[t]) lt = t;
      exp_resp = 0;
      if (c == LD && idx < LINES && lt != 0) begin
         exp_resp = 4'(lt);
         busy_until[lt] = ecnt + LAT;
         pq.push_back('{tag: lt, idx: idx, ret: ecnt + LAT - 1});
      end else if (c == ST && idx < LINES) begin
         exp_resp = 4'(lt);
         n    = 1 << s;
         base = (offs / n) * n;
         if (idx < 16)
            for (int b = 0; b < 8; b++)
               if (b >= base && b < base + n) mm[idx][b*8 +: 8] = d[(b-base)*8 +: 8];
      end
      exp_tag = 0; exp_data = 0;
      if (pq.size() > 0 && pq[0].ret == ecnt) begin
         exp_tag  = 4'(pq[0].tag);
         exp_data = mm[pq[0].idx];
         void'(pq.pop_front());
      end
      ecnt++;
   endtask

   task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                       input logic [1:0] s, input logic rst);
      bus.proc2mem_command = c;
      bus.proc2mem_addr    = a;
      bus.proc2mem_data    = d;
      bus.proc2mem_size    = s;
      reset                = rst;
      @(posedge clock);
      model(rst, c, a, d, s);
      @(negedge clock);
      o_resp = bus.mem2proc_response;
      o_tag  = bus.mem2proc_tag;
      o_data = bus.mem2proc_data;
      chk("resp", o_resp, exp_resp);
      chk("tag",  o_tag,  exp_tag);
      chk("data", o_data, exp_data);
   endtask

   task automatic idle();
      step(2'd0, 32'd0, 64'd0, 2'd0, 1'b0);
   endtask

   task automatic drain();
      repeat (LAT + 2) idle();
   endtask

   task automatic run_load(input logic [31:0] a, input logic [63:0] want, input string name);
      logic [3:0] tg;
      step(LD, a, 64'd0, 2'd0, 1'b0);
      tg = o_resp;
      for (int i = 0; i < LAT + 2 && o_tag == 0; i++) idle();
      chk({name, "_tag"}, o_tag, tg);
      chk({name, "_data"}, o_data, want);
   endtask

   initial begin
      int seen;
      logic [31:0] a;
      int ridx;

      step(2'd0, 32'd0, 64'd0, 2'd0, 1'b1);
      step(LD, 32'h10, 64'd0, 2'd0, 1'b1);
      chk("rst_resp", o_resp, 0);
      chk("rst_tag", o_tag, 0);
      chk("rst_data", o_data, 0);

      for (int i = 0; i < 16; i++)
         step(ST, 32'(i * 8), (i == 2) ? 64'h1122334455667788 : {$urandom, $urandom}, 2'd3, 1'b0);

      // Single load latency
      step(LD, 32'h10, 64'd0, 2'd0, 1'b0);
      chk("ld_resp", o_resp, 1);
      repeat (LAT - 2) idle();
      idle();
      chk("ld_tag", o_tag, 1);
      chk("ld_data", o_data, 64'h1122334455667788);
      idle();
      chk("ld_tag_clr", o_tag, 0);
      drain();

      // Sub-word stores
      step(ST, 32'h10, 64'd0, 2'd3, 1'b0);
      step(ST, 32'h13, 64'hAB, 2'd0, 1'b0);
      run_load(32'h10, 64'h00000000AB000000, "byte_st");
      step(ST, 32'h14, 64'hDEADBEEF, 2'd2, 1'b0);
      run_load(32'h10, 64'hDEADBEEFAB000000, "word_st");
      drain();

      // Back-to-back loads return in order
      for (int i = 1; i <= 3; i++) begin
         step(LD, 32'(i * 8), 64'd0, 2'd0, 1'b0);
         chk("b2b_resp", o_resp, 4'(i));
      end
      repeat (LAT - 4) idle();
      for (int i = 1; i <= 3; i++) begin
         idle();
         chk("b2b_tag", o_tag, 4'(i));
      end
      drain();

      // Out-of-range and command 3 are rejected
      step(LD, 32'(LINES * 8), 64'd0, 2'd0, 1'b0);
      chk("oor_resp", o_resp, 0);
      step(2'd3, 32'h10, 64'd0, 2'd0, 1'b0);
      chk("cmd3_resp", o_resp, 0);
      seen = 0;
      repeat (LAT + 2) begin idle(); if (o_tag != 0) seen++; end
      chk("oor_no_ret", 64'(seen), 0);

      // Tag exhaustion
      for (int i = 1; i <= 16; i++) step(LD, 32'((i % 16) * 8), 64'd0, 2'd0, 1'b0);
      chk("exh_16th", o_resp, 0);
      step(LD, 32'h10, 64'd0, 2'd0, 1'b0);
      chk("exh_retry", o_resp, 1);
      drain();

      // Reset with loads in flight
      step(LD, 32'h10, 64'd0, 2'd0, 1'b0);
      step(LD, 32'h18, 64'd0, 2'd0, 1'b0);
      idle();
      step(2'd0, 32'd0, 64'd0, 2'd0, 1'b1);
      chk("mid_rst_out", {o_resp, o_tag}, 0);
      seen = 0;
      repeat (LAT + 2) begin idle(); if (o_tag != 0) seen++; end
      chk("mid_rst_no_ret", 64'(seen), 0);
      step(LD, 32'h10, 64'd0, 2'd0, 1'b0);
      chk("post_rst_resp", o_resp, 1);
      for (int i = 0; i < LAT + 2 && o_tag == 0; i++) idle();
      chk("post_rst_data", o_data, 64'hDEADBEEFAB000000);
      drain();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         ridx = ($urandom % 16 == 0) ? LINES + int'($urandom % 4) : int'($urandom % 16);
         a    = 32'(ridx * 8) | 32'($urandom % 8);
         step(2'($urandom), a, {$urandom, $urandom}, 2'($urandom), ($urandom % 64) == 0);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
